// File: rtl/xdisplay_scan.sv
`default_nettype none
// ============================================================================
// Module      : xdisplay_scan
// Description : Time-multiplexed driver for a multi-digit common-anode
//               7-segment display. Holds one raw segment pattern per digit
//               and walks the anode enables one digit per slot, with a short
//               all-dark gap at the start of every slot to suppress ghosting.
//
// Ports       : clk      in   system clock (single domain)
//               rst      in   synchronous active-high reset
//               sel      in   write strobe, one write per cycle
//               addr     in   [ADDR_W-1:0] digit index being written
//               data_in  in   [7:0] raw pattern {dp,g,f,e,d,c,b,a}, 1 = lit
//               en       in   scan enable; 0 = dark, scan parked at digit 0
//               out      out  [N_DIGITS+8-1:0] registered {anodes, segs}
//
// Revision    : 1.0 - initial release
// ============================================================================
module xdisplay_scan #(
    parameter int N_DIGITS      = 4,
    parameter int ADDR_W        = 2,
    parameter int SLOT_CYCLES   = 50000,
    parameter int BLANK_CYCLES  = 500,
    parameter int ANODE_ACT_LOW = 1,
    parameter int SEG_ACT_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [7:0]            data_in,
    input  logic                  en,
    output logic [N_DIGITS+7:0]   out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(SLOT_CYCLES);

    localparam logic [CNT_W-1:0]    c_cnt_last  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [N_DIGITS-1:0] c_anode_off = (ANODE_ACT_LOW != 0) ?
                                                  {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [7:0]          c_seg_off   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS+7:0] c_out_off   = {c_anode_off, c_seg_off};

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    generate
        if ((N_DIGITS < 2) || (N_DIGITS > 8) ||
            ((N_DIGITS & (N_DIGITS - 1)) != 0) ||
            ((1 << ADDR_W) != N_DIGITS)) begin : g_bad_digits
            $error("xdisplay_scan: N_DIGITS must be a power of two in 2..8 and equal 2**ADDR_W");
        end
        if (SLOT_CYCLES < 2) begin : g_bad_slot
            $error("xdisplay_scan: SLOT_CYCLES must be at least 2");
        end
        if ((BLANK_CYCLES < 0) || (BLANK_CYCLES >= SLOT_CYCLES)) begin : g_bad_blank
            $error("xdisplay_scan: BLANK_CYCLES must lie in 0..SLOT_CYCLES-1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]          r_digit [N_DIGITS];
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic [N_DIGITS+7:0] r_out;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_slot_end;
    logic                w_in_blank;
    logic                w_hit_idx;
    logic [7:0]          w_seg_raw;
    logic [N_DIGITS-1:0] w_anode_onehot;
    logic [N_DIGITS+7:0] w_show;

    assign w_slot_end = (r_cnt == c_cnt_last);

    // With no blanking gap the comparison would be against zero and is
    // always false, so it is removed structurally rather than left to the
    // optimiser.
    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign w_in_blank = (r_cnt < CNT_W'(BLANK_CYCLES));
        end else begin : g_no_blank
            assign w_in_blank = 1'b0;
        end
    endgenerate

    // A write aimed at the digit currently being shown is forwarded straight
    // to the output so the display never shows the stale pattern for a cycle.
    assign w_hit_idx = sel && (addr == r_idx);
    assign w_seg_raw = w_hit_idx ? data_in : r_digit[r_idx];

    // One-hot by construction: at most one anode can ever be driven active.
    assign w_anode_onehot = N_DIGITS'(1) << r_idx;

    assign w_show = {w_anode_onehot ^ c_anode_off, w_seg_raw ^ c_seg_off};

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_digit[i] <= 8'h00;
            end
            r_cnt <= '0;
            r_idx <= '0;
            r_out <= c_out_off;
        end else begin
            // Pattern writes are independent of the scan state.
            if (sel) begin
                r_digit[addr] <= data_in;
            end

            if (!en) begin
                // Parked: dark output, next enable starts a fresh digit-0 slot
                // including its full blanking phase.
                r_cnt <= '0;
                r_idx <= '0;
                r_out <= c_out_off;
            end else begin
                if (w_slot_end) begin
                    r_cnt <= '0;
                    // N_DIGITS == 2**ADDR_W, so natural overflow is the wrap.
                    r_idx <= r_idx + ADDR_W'(1);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end

                // Output reflects the pre-edge position, one cycle behind
                // the counter.
                r_out <= w_in_blank ? c_out_off : w_show;
            end
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire
